// File: rtl/oven_pkg.sv
// Shared types and widths for the oven cycle controller, display and entry logic.
package oven_pkg;

  localparam int unsigned TEMP_W = 10;
  localparam int unsigned TIME_W = 13;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREHEAT = 3'd1,
    ST_BAKE    = 3'd2,
    ST_DONE    = 3'd3,
    ST_FAULT   = 3'd4
  } oven_state_e;

endpackage

// File: rtl/oven_cycle_ctrl_if.sv
// Entry-side controls and display/heater outputs of the oven cycle controller.
interface oven_cycle_ctrl_if;
  import oven_pkg::*;

  logic              tick_1hz;
  logic              start;
  logic              cancel;
  logic [TEMP_W-1:0] target_temp;
  logic [TIME_W-1:0] bake_time;
  logic [TEMP_W-1:0] current_temp;
  logic              heater_on;
  logic [2:0]        phase;
  logic [TIME_W-1:0] remaining_time;
  logic              buzzer;
  logic              fault;

  modport master (
    output tick_1hz, start, cancel, target_temp, bake_time, current_temp,
    input  heater_on, phase, remaining_time, buzzer, fault
  );

  modport slave (
    input  tick_1hz, start, cancel, target_temp, bake_time, current_temp,
    output heater_on, phase, remaining_time, buzzer, fault
  );

endinterface

// File: rtl/oven_cycle_ctrl_heater.sv
// Heater element enable with hysteresis: off at or above target, back on below target - HYST.
module heater_hysteresis
  import oven_pkg::*;
#(
  parameter int unsigned HYST = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [TEMP_W-1:0] target,
  input  logic [TEMP_W-1:0] current,
  output logic              heater_on
);

  logic [TEMP_W-1:0] low_thr_s;
  logic              heater_nxt_s;
  logic              heater_r;

  // Re-enable threshold (saturating at 0) and next heater decision.
  always_comb begin
    low_thr_s    = {TEMP_W{1'b0}};
    heater_nxt_s = 1'b0;
    if (target >= TEMP_W'(HYST)) begin
      low_thr_s = target - TEMP_W'(HYST);
    end else begin
      low_thr_s = {TEMP_W{1'b0}};
    end
    if (!enable) begin
      heater_nxt_s = 1'b0;
    end else if (current >= target) begin
      heater_nxt_s = 1'b0;
    end else if (current < low_thr_s) begin
      heater_nxt_s = 1'b1;
    end else begin
      heater_nxt_s = heater_r;
    end
  end

  // Heater register; reset drops the element without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      heater_r <= 1'b0;
    end else begin
      heater_r <= heater_nxt_s;
    end
  end

  assign heater_on = heater_r;

endmodule

// File: rtl/oven_cycle_ctrl.sv
// Oven cycle sequencer: IDLE -> PREHEAT -> BAKE -> DONE -> IDLE, with over-temperature
// and preheat-timeout faults. All timing is counted in one-second ticks.
module oven_cycle_ctrl
  import oven_pkg::*;
#(
  parameter int unsigned HYST            = 5,
  parameter int unsigned MAX_TEMP        = 500,
  parameter int unsigned PREHEAT_TIMEOUT = 900,
  parameter int unsigned BUZZ_SECONDS    = 10
) (
  input logic              clk,
  input logic              rst_n,
  oven_cycle_ctrl_if.slave bus
);

  oven_state_e       state_r;
  oven_state_e       state_nxt_s;
  logic [TEMP_W-1:0] target_r;
  logic [TEMP_W-1:0] heat_target_s;
  logic [TIME_W-1:0] bake_r;
  logic [TIME_W-1:0] rem_r;
  logic [TIME_W-1:0] rem_nxt_s;
  logic [TIME_W-1:0] pre_cnt_r;
  logic [TIME_W-1:0] pre_cnt_nxt_s;
  logic [TIME_W-1:0] buzz_cnt_r;
  logic [TIME_W-1:0] buzz_cnt_nxt_s;
  logic              start_ok_s;
  logic              over_temp_s;
  logic              heater_en_s;
  logic              heater_s;
  logic              buzzer_r;
  logic              fault_r;

  // Next-state selection: cancel beats over-temperature beats normal sequencing.
  always_comb begin
    start_ok_s  = bus.start && !bus.cancel && (state_r == ST_IDLE);
    over_temp_s = (bus.current_temp > TEMP_W'(MAX_TEMP));
    state_nxt_s = state_r;
    if (bus.cancel) begin
      state_nxt_s = ST_IDLE;
    end else if (over_temp_s && (state_r != ST_IDLE)) begin
      state_nxt_s = ST_FAULT;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_ok_s) begin
            state_nxt_s = ST_PREHEAT;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_PREHEAT: begin
          if (bus.current_temp >= target_r) begin
            state_nxt_s = ST_BAKE;
          end else if (pre_cnt_r >= TIME_W'(PREHEAT_TIMEOUT)) begin
            state_nxt_s = ST_FAULT;
          end else begin
            state_nxt_s = ST_PREHEAT;
          end
        end
        ST_BAKE: begin
          if (rem_r == {TIME_W{1'b0}}) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_BAKE;
          end
        end
        ST_DONE: begin
          if (buzz_cnt_r >= TIME_W'(BUZZ_SECONDS)) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        ST_FAULT: state_nxt_s = ST_FAULT;
        default:  state_nxt_s = ST_FAULT;
      endcase
    end
  end

  // Counters clear on any state change, so a tick coinciding with an entry is never counted.
  always_comb begin
    pre_cnt_nxt_s  = pre_cnt_r;
    buzz_cnt_nxt_s = buzz_cnt_r;
    rem_nxt_s      = rem_r;
    if (state_nxt_s != state_r) begin
      pre_cnt_nxt_s  = {TIME_W{1'b0}};
      buzz_cnt_nxt_s = {TIME_W{1'b0}};
      if (state_nxt_s == ST_BAKE) begin
        rem_nxt_s = bake_r;
      end else begin
        rem_nxt_s = {TIME_W{1'b0}};
      end
    end else begin
      if ((state_r == ST_PREHEAT) && bus.tick_1hz && (pre_cnt_r < TIME_W'(PREHEAT_TIMEOUT))) begin
        pre_cnt_nxt_s = pre_cnt_r + TIME_W'(1);
      end else begin
        pre_cnt_nxt_s = pre_cnt_r;
      end
      if ((state_r == ST_DONE) && bus.tick_1hz && (buzz_cnt_r < TIME_W'(BUZZ_SECONDS))) begin
        buzz_cnt_nxt_s = buzz_cnt_r + TIME_W'(1);
      end else begin
        buzz_cnt_nxt_s = buzz_cnt_r;
      end
      if ((state_r == ST_BAKE) && bus.tick_1hz && (rem_r != {TIME_W{1'b0}})) begin
        rem_nxt_s = rem_r - TIME_W'(1);
      end else begin
        rem_nxt_s = rem_r;
      end
    end
  end

  // The heater follows the state being entered, using the setpoint being latched on start.
  always_comb begin
    heater_en_s = (state_nxt_s == ST_PREHEAT) || (state_nxt_s == ST_BAKE);
    if (start_ok_s) begin
      heat_target_s = bus.target_temp;
    end else begin
      heat_target_s = target_r;
    end
  end

  heater_hysteresis #(
    .HYST (HYST)
  ) u_heater (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (heater_en_s),
    .target    (heat_target_s),
    .current   (bus.current_temp),
    .heater_on (heater_s)
  );

  // State, counters, latched setpoints and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      target_r   <= {TEMP_W{1'b0}};
      bake_r     <= {TIME_W{1'b0}};
      rem_r      <= {TIME_W{1'b0}};
      pre_cnt_r  <= {TIME_W{1'b0}};
      buzz_cnt_r <= {TIME_W{1'b0}};
      buzzer_r   <= 1'b0;
      fault_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      rem_r      <= rem_nxt_s;
      pre_cnt_r  <= pre_cnt_nxt_s;
      buzz_cnt_r <= buzz_cnt_nxt_s;
      buzzer_r   <= (state_nxt_s == ST_DONE);
      fault_r    <= (state_nxt_s == ST_FAULT);
      if (start_ok_s) begin
        target_r <= bus.target_temp;
        bake_r   <= bus.bake_time;
      end else begin
        target_r <= target_r;
        bake_r   <= bake_r;
      end
    end
  end

  assign bus.phase          = state_r;
  assign bus.remaining_time = rem_r;
  assign bus.heater_on      = heater_s;
  assign bus.buzzer         = buzzer_r;
  assign bus.fault          = fault_r;

endmodule

// File: tb/tb_oven_cycle_ctrl.sv
// Directed vector bench for oven_cycle_ctrl: a table of one-cycle vectors plus
// hand-written preheat-timeout and asynchronous-reset sequences.
module tb_oven_cycle_ctrl;
  import oven_pkg::*;

  typedef struct {
    logic        tk;
    logic        st;
    logic        cn;
    logic [9:0]  tgt;
    logic [12:0] bk;
    logic [9:0]  cur;
    logic [2:0]  ph;
    logic        ht;
    logic [12:0] rem;
    logic        bz;
    logic        ft;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vecs[$];

  oven_cycle_ctrl_if bus ();

  oven_cycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic add(input int tk, input int st, input int cn, input int tgt, input int bk,
                     input int cur, input int ph, input int ht, input int rem, input int bz,
                     input int ft);
    vec_t v;
    v.tk = 1'(tk);   v.st = 1'(st);    v.cn = 1'(cn);
    v.tgt = 10'(tgt); v.bk = 13'(bk);  v.cur = 10'(cur);
    v.ph = 3'(ph);   v.ht = 1'(ht);    v.rem = 13'(rem);
    v.bz = 1'(bz);   v.ft = 1'(ft);
    vecs.push_back(v);
  endtask

  task automatic drive(input int tk, input int st, input int cn, input int tgt, input int bk,
                       input int cur);
    bus.tick_1hz     = 1'(tk);
    bus.start        = 1'(st);
    bus.cancel       = 1'(cn);
    bus.target_temp  = 10'(tgt);
    bus.bake_time    = 13'(bk);
    bus.current_temp = 10'(cur);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int ph, input int ht, input int rem,
                       input int bz, input int ft);
    n_vec++;
    if (bus.phase !== 3'(ph) || bus.heater_on !== 1'(ht) || bus.remaining_time !== 13'(rem) ||
        bus.buzzer !== 1'(bz) || bus.fault !== 1'(ft)) begin
      n_bad++;
      $display("FAIL %s: got phase=%0d heater=%0b rem=%0d buzzer=%0b fault=%0b, expected phase=%0d heater=%0d rem=%0d buzzer=%0d fault=%0d",
               nm, bus.phase, bus.heater_on, bus.remaining_time, bus.buzzer, bus.fault,
               ph, ht, rem, bz, ft);
    end
  endtask

  initial begin
    //  tk st cn tgt  bk  cur   ph ht rem bz ft
    add(0, 0, 0, 300, 3, 250,   0, 0, 0, 0, 0);   // idle, nothing happens
    add(1, 1, 0, 300, 3, 250,   1, 1, 0, 0, 0);   // start (tick not counted)
    add(1, 0, 0, 300, 3, 280,   1, 1, 0, 0, 0);
    add(0, 0, 0, 300, 3, 296,   1, 1, 0, 0, 0);   // inside hysteresis band: hold
    add(1, 0, 0, 300, 3, 300,   2, 0, 3, 0, 0);   // reach target; tick not counted
    add(1, 0, 0, 300, 3, 298,   2, 0, 2, 0, 0);
    add(1, 0, 0, 300, 3, 298,   2, 0, 1, 0, 0);
    add(0, 0, 0, 300, 3, 298,   2, 0, 1, 0, 0);
    add(1, 0, 0, 300, 3, 298,   2, 0, 0, 0, 0);
    add(0, 0, 0, 300, 3, 298,   3, 0, 0, 1, 0);   // DONE, buzzer on
    add(0, 1, 0, 200, 7, 298,   3, 0, 0, 1, 0);   // start ignored in DONE
    for (int i = 0; i < 10; i++) add(1, 0, 0, 300, 3, 298, 3, 0, 0, 1, 0);
    add(0, 0, 0, 300, 3, 298,   0, 0, 0, 0, 0);   // back to IDLE after 10 ticks
    add(0, 1, 0, 300, 50, 301,  1, 0, 0, 0, 0);   // hysteresis run
    add(0, 0, 0, 300, 50, 301,  2, 0, 50, 0, 0);
    add(0, 0, 0, 300, 50, 296,  2, 0, 50, 0, 0);
    add(0, 0, 0, 300, 50, 294,  2, 1, 50, 0, 0);
    add(0, 0, 0, 300, 50, 501,  4, 0, 0, 0, 1);   // over-temperature in BAKE
    add(0, 1, 0, 300, 50, 300,  4, 0, 0, 0, 1);   // start ignored in FAULT
    add(0, 0, 1, 300, 50, 501,  0, 0, 0, 0, 0);   // cancel clears fault
    add(0, 1, 0, 300, 20, 300,  1, 0, 0, 0, 0);
    add(0, 0, 0, 300, 20, 300,  2, 0, 20, 0, 0);
    add(0, 0, 0, 300, 20, 290,  2, 1, 20, 0, 0);
    add(0, 0, 1, 300, 20, 501,  0, 0, 0, 0, 0);   // cancel beats over-temp
    add(0, 1, 1, 300, 20, 250,  0, 0, 0, 0, 0);   // start ignored while cancel
    add(0, 0, 0, 300, 20, 501,  0, 0, 0, 0, 0);   // over-temp ignored in IDLE
    add(0, 1, 0, 300, 0, 310,   1, 0, 0, 0, 0);   // zero bake time
    add(0, 0, 0, 300, 0, 310,   2, 0, 0, 0, 0);
    add(0, 0, 0, 300, 0, 310,   3, 0, 0, 1, 0);
    add(0, 1, 0, 300, 9, 310,   3, 0, 0, 1, 0);   // start ignored in DONE
    add(0, 0, 1, 300, 9, 310,   0, 0, 0, 0, 0);

    drive(0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 check("reset", 0, 0, 0, 0, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("post_reset", 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].tk, vecs[i].st, vecs[i].cn, vecs[i].tgt, vecs[i].bk, vecs[i].cur);
      step();
      check($sformatf("vec%0d", i), vecs[i].ph, vecs[i].ht, vecs[i].rem, vecs[i].bz, vecs[i].ft);
    end

    // Preheat timeout with the oven stuck at 100F.
    drive(0, 1, 0, 300, 5, 100);
    step();
    check("to_start", 1, 1, 0, 0, 0);
    drive(0, 0, 0, 300, 5, 100);
    for (int i = 0; i < 899; i++) begin
      bus.tick_1hz = 1'b1;
      step();
      bus.tick_1hz = 1'b0;
      step();
    end
    check("to_899", 1, 1, 0, 0, 0);
    bus.tick_1hz = 1'b1;
    step();
    bus.tick_1hz = 1'b0;
    step();
    check("to_900", 4, 0, 0, 0, 1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    check("to_start_ign", 4, 0, 0, 0, 1);
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    check("to_cancel", 0, 0, 0, 0, 0);

    // Asynchronous reset mid-cycle while baking with the heater on.
    drive(0, 1, 0, 300, 20, 300);
    step();
    drive(0, 0, 0, 300, 20, 300);
    step();
    drive(0, 0, 0, 300, 20, 250);
    step();
    check("ar_heat", 2, 1, 20, 0, 0);
    #3 rst_n = 1'b0;
    #1 check("ar_reset", 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
